// File: rtl/als_spi_reader.sv
// rtl/als_spi_reader.sv - periodic SPI read master for the 8-bit ambient-light sensor
module als_spi_reader #(
    parameter int CLK_DIV       = 8,
    parameter int SAMPLE_PERIOD = 100000,
    parameter int PERIOD_W      = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sdo,
    output logic       ncs,
    output logic       sck,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0]     PH_LAST     = PH_W'(CLK_DIV - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, DONE} state_t;

    state_t              state, state_d;
    logic [PERIOD_W-1:0] period_cnt;
    logic                pending;
    logic [PH_W-1:0]     phase, phase_d;
    logic [4:0]          bit_cnt, bit_cnt_d;
    logic [15:0]         shift, shift_d;
    logic                ncs_d, sck_d, valid_d, err_d, start;
    logic [7:0]          sample_d;
    logic                wrap, phase_last;

    assign wrap       = en && (period_cnt == PERIOD_LAST);
    assign phase_last = (phase == PH_LAST);
    assign busy       = (state != IDLE);

    // Period counter and the start request it raises on every wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            pending    <= 1'b0;
        end else begin
            if (!en || wrap) period_cnt <= '0;
            else             period_cnt <= period_cnt + PERIOD_W'(1);
            if (!en)        pending <= 1'b0;
            else if (wrap)  pending <= 1'b1;
            else if (start) pending <= 1'b0;
        end
    end

    // State register plus all registered outputs and the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            ncs          <= 1'b1;
            sck          <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_d;
            phase        <= phase_d;
            bit_cnt      <= bit_cnt_d;
            shift        <= shift_d;
            ncs          <= ncs_d;
            sck          <= sck_d;
            sample       <= sample_d;
            sample_valid <= valid_d;
            frame_err    <= err_d;
        end
    end

    // Frame sequencing: setup, 16 low/high sck phase pairs, then publish
    always_comb begin
        state_d   = state;
        phase_d   = phase + PH_W'(1);
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        ncs_d     = ncs;
        sck_d     = sck;
        sample_d  = sample;
        valid_d   = 1'b0;
        err_d     = frame_err;
        start     = 1'b0;
        case (state)
            IDLE: begin
                ncs_d   = 1'b1;
                sck_d   = 1'b1;
                phase_d = '0;
                if (pending && en) begin
                    start     = 1'b1;
                    ncs_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (phase_last) begin
                    sck_d   = 1'b0;
                    phase_d = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                // sdo is stable here: the sensor moved it right after the falling edge
                if (phase_last) begin
                    shift_d   = {shift[14:0], sdo};
                    sck_d     = 1'b1;
                    bit_cnt_d = bit_cnt + 5'd1;
                    phase_d   = '0;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    phase_d = '0;
                    if (bit_cnt == 5'd16) begin
                        ncs_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        sck_d   = 1'b0;
                        state_d = LOW;
                    end
                end
            end
            DONE: begin
                sample_d = shift[11:4];
                err_d    = (|shift[15:12]) || (|shift[3:0]);
                valid_d  = 1'b1;
                phase_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                phase_d = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_als_spi_reader.sv
// tb/tb_als_spi_reader.sv - randomized self-checking bench for als_spi_reader
module tb_als_spi_reader;

    localparam int D  = 2;
    localparam int SP = 100;
    localparam int FL = 33 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sdo = 1'b0;
    logic       ncs, sck, sample_valid, frame_err, busy;
    logic [7:0] sample;

    int checks = 0;
    int errors = 0;

    als_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(SP), .PERIOD_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sdo(sdo), .ncs(ncs), .sck(sck),
        .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sensor: word latched at ncs fall, first bit already on sdo, later bits after each sck fall
    logic [15:0] next_word = 16'h0;
    logic [15:0] cur_word;
    int          nfall;
    logic [15:0] word_q[$];

    always @(negedge ncs) begin
        cur_word = next_word;
        nfall    = 0;
        sdo      = cur_word[15];
        word_q.push_back(cur_word);
    end

    always @(negedge sck) begin
        if (!ncs) begin
            if (nfall > 0) cur_word = cur_word << 1;
            nfall++;
            sdo = cur_word[15];
        end
    end

    always @(negedge rst_n) word_q.delete();

    // Behavioural model: position within frame derived from the period timing
    int         m_pos, m_cnt;
    logic       m_pend, m_valid, m_err;
    logic [7:0] m_sample;
    logic [15:0] m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = -1; m_cnt = 0; m_pend = 0; m_valid = 0;
            m_err = 0; m_sample = 0; m_word = 0;
        end else begin
            int  p;
            logic st;
            p  = m_pos;
            st = (p == -1) && m_pend && en;
            if (p >= D && p < FL && ((p - D) % (2 * D)) == D - 1) m_word = {m_word[14:0], sdo};
            m_valid = (p == FL);
            if (p == FL) begin
                m_sample = m_word[11:4];
                m_err    = (m_word[15:12] != 0) || (m_word[3:0] != 0);
            end
            if (p == -1) m_pos = st ? 0 : -1;
            else         m_pos = (p == FL) ? -1 : p + 1;
            if (!en)              m_pend = 0;
            else if (m_cnt == SP - 1) m_pend = 1;
            else if (st)          m_pend = 0;
            if (!en) m_cnt = 0;
            else     m_cnt = (m_cnt == SP - 1) ? 0 : m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model, plus scoreboard on each valid pulse
    logic prev_valid = 1'b0;
    logic prev_ncs = 1'b1;
    int   cyc = 0;
    logic rec = 1'b0;
    int   fall_t[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("ncs", ncs, !(m_pos >= 0 && m_pos < FL));
            chk("sck", sck, (m_pos >= D && m_pos < FL) ? (((m_pos - D) / D) % 2 == 1) : 1'b1);
            chk("busy", busy, m_pos >= 0);
            chk("sample_valid", sample_valid, m_valid);
            chk("sample", sample, m_sample);
            chk("frame_err", frame_err, m_err);
            if (sample_valid) begin
                logic [15:0] w;
                chk("valid_not_back_to_back", prev_valid, 1'b0);
                chk("word_queued", word_q.size() > 0, 1'b1);
                if (word_q.size() > 0) begin
                    w = word_q.pop_front();
                    chk("sb_sample", sample, w[11:4]);
                    chk("sb_err", frame_err, (w[15:12] != 0) || (w[3:0] != 0));
                end
            end
            if (rec && prev_ncs && !ncs) fall_t.push_back(cyc);
        end
        prev_valid = sample_valid;
        prev_ncs   = ncs;
    end

    task automatic wait_valid(input int max);
        int n = 0;
        @(negedge clk);
        while (!sample_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", n < max, 1'b1);
    endtask

    task automatic wait_ncs_fall();
        int n = 0;
        while (!ncs && n < 300) begin @(negedge clk); n++; end
        while (ncs && n < 300) begin @(negedge clk); n++; end
        chk("ncs_fall_timeout", n < 300, 1'b1);
    endtask

    initial begin
        int n, falls, vcnt;
        logic prev_sck;
        logic [15:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ncs", ncs, 1'b1);
        chk("rst_sck", sck, 1'b1);
        chk("rst_sample", sample, 8'h00);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Test 1: single frame timing and data
        next_word = 16'h0AB0;
        rst_n = 1'b1;
        en    = 1'b1;
        wait_ncs_fall();
        n = 0; falls = 0; prev_sck = sck;
        while (!ncs && n < 200) begin
            n++;
            @(negedge clk);
            if (prev_sck && !sck && !ncs) falls++;
            prev_sck = sck;
        end
        chk("t1_ncs_low_len", n, FL);
        chk("t1_sck_falls", falls, 16);
        next_word = 16'h8AB1;
        wait_valid(200);
        chk("t1_sample", sample, 8'hAB);
        chk("t1_err", frame_err, 1'b0);

        // Test 2: pad error then clean frame
        wait_valid(200);
        chk("t2_sample", sample, 8'hAB);
        chk("t2_err", frame_err, 1'b1);
        next_word = 16'h0550;
        wait_valid(200);
        chk("t2b_sample", sample, 8'h55);
        chk("t2b_err", frame_err, 1'b0);

        // Test 3: periodic spacing over 1000 cycles
        next_word = 16'h0FF0;
        rec = 1'b1; vcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sample_valid) vcnt++;
        end
        rec = 1'b0;
        chk("t3_valid_count", vcnt, 10);
        chk("t3_fall_count", fall_t.size(), 10);
        for (int i = 1; i < fall_t.size(); i++) chk("t3_fall_gap", fall_t[i] - fall_t[i-1], SP);

        // Test 4: asynchronous reset mid-frame
        next_word = 16'h0120;
        wait_ncs_fall();
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_ncs", ncs, 1'b1);
        chk("t4_sck", sck, 1'b1);
        chk("t4_sample", sample, 8'h00);
        chk("t4_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        while (ncs && n < 300) begin n++; @(negedge clk); end
        chk("t4_first_frame_delay", n, SP);
        wait_valid(200);
        chk("t4_sample_after", sample, 8'h12);

        // Test 5: en dropped mid-frame
        next_word = 16'h0C30;
        wait_ncs_fall();
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_valid(200);
        chk("t5_sample", sample, 8'hC3);
        chk("t5_err", frame_err, 1'b0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!ncs) n++;
        end
        chk("t5_no_ncs_activity", n, 0);

        // Test 6: random clean frames
        en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            w = 16'($urandom) & 16'h0FF0;
            next_word = w;
            wait_valid(250);
            chk("t6_sample", sample, w[11:4]);
            chk("t6_err", frame_err, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
